// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO
// Ports:
//   clk          clock
//   rst          asynchronous active-low reset
//   address      byte address from core; window is BASE_ADDR..BASE_ADDR+15
//   write_data   store data
//   write_mask   byte-lane enables, bit0 = write_data[7:0]
//   write_enable store strobe
//   read_data    combinational register read data (0 when not hit)
//   hit          address falls inside this block's window
//   tx           serial output, idle high
//   irq          registered interrupt (only when UART_TX_IRQ_EN is defined)
// Registers: 0x0 TXDATA, 0x4 STATUS, 0x8 DIV, 0xC reserved (IE when UART_TX_IRQ_EN).
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] RESET_DIV  = 16'd867
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [3:0]  write_mask,
    input  logic        write_enable,
    output logic [31:0] read_data,
    output logic        hit,
    output logic        tx
`ifdef UART_TX_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_n;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [15:0]   div;
    logic [15:0]   baud, baud_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;
    logic          pop, done;
    logic [1:0]    off;
    logic          wr_hit, push_req, push_ok, empty, full;
    logic [31:0]   status, ie_rd;
    logic          unused;

    assign hit      = address[31:4] == BASE_ADDR[31:4];
    assign off      = address[3:2];
    assign wr_hit   = write_enable & hit;
    assign empty    = count == '0;
    assign full     = count == DEPTH;
    assign push_req = wr_hit & (off == 2'd0) & write_mask[0];
    // Uses the pre-edge count, so a pop on the same edge never makes room.
    assign push_ok  = push_req & ~full;
    assign status   = {19'd0, 5'(count), 4'd0, overflow, empty, full, (state != IDLE) | ~empty};
    assign done     = baud == 16'd0;

    assign read_data = !hit          ? 32'd0 :
                       off == 2'd1   ? status :
                       off == 2'd2   ? {16'd0, div} :
                       off == 2'd3   ? ie_rd : 32'd0;

    assign unused = ^{write_data[31:16], write_mask[3:2], address[1:0]};

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= write_data[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            div      <= RESET_DIV;
            baud     <= 16'd0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop);
            if (push_req & full)
                overflow <= 1'b1;
            else if (wr_hit & (off == 2'd1) & write_mask[0] & write_data[3])
                overflow <= 1'b0;
            if (wr_hit & (off == 2'd2) & write_mask[0]) div[7:0]  <= write_data[7:0];
            if (wr_hit & (off == 2'd2) & write_mask[1]) div[15:8] <= write_data[15:8];
        end
    end

    // The baud counter reloads from the live DIV at every bit boundary, so a
    // DIV write mid-frame only affects bits that start after it.
    always_comb begin
        state_n = state;
        baud_n  = done ? div : baud - 16'd1;
        bit_n   = bit_idx;
        shift_n = shift;
        pop     = 1'b0;
        tx      = 1'b1;
        case (state)
            IDLE: begin
                baud_n = div;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    state_n = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (done) begin
                    bit_n   = 3'd0;
                    state_n = DATA;
                end
            end
            DATA: begin
                tx = shift[0];
                if (done) begin
                    shift_n = shift >> 1;
                    bit_n   = bit_idx + 3'd1;
                    state_n = bit_idx == 3'd7 ? STOP : DATA;
                end
            end
            STOP: begin
                if (done) begin
                    pop     = ~empty;
                    shift_n = empty ? shift : mem[rd_ptr];
                    state_n = empty ? IDLE : START;
                end
            end
        endcase
    end

`ifdef UART_TX_IRQ_EN
    logic [1:0] ie;

    assign ie_rd = {30'd0, ie};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ie  <= 2'd0;
            irq <= 1'b0;
        end else begin
            if (wr_hit & (off == 2'd3) & write_mask[0]) ie <= write_data[1:0];
            irq <= (ie[0] & empty & (state == IDLE)) | (ie[1] & overflow);
        end
    end
`else
    assign ie_rd = 32'd0;
`endif
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;
    localparam logic [31:0] A_TX  = 32'h1000_0000;
    localparam logic [31:0] A_ST  = 32'h1000_0004;
    localparam logic [31:0] A_DIV = 32'h1000_0008;
    localparam logic [31:0] A_RSV = 32'h1000_000C;

    logic        clk, rst, write_enable, hit, tx;
    logic [31:0] address, write_data, read_data;
    logic [3:0]  write_mask;
`ifdef UART_TX_IRQ_EN
    logic        irq;
`endif

    int  nvec = 0, nfail = 0, cyc = 0, rx_cnt = 0, per = 4;
    bit  mon_en = 0;
    logic [7:0] exp_q[$];
    int         st_q[$];

    mmio_uart_tx dut (
        .clk(clk), .rst(rst), .address(address), .write_data(write_data),
        .write_mask(write_mask), .write_enable(write_enable),
        .read_data(read_data), .hit(hit), .tx(tx)
`ifdef UART_TX_IRQ_EN
        , .irq(irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        address = a; write_data = d; write_mask = m; write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        write_enable = 1'b0;
        address = a;
        #1;
        d = read_data;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] e);
        logic [31:0] d;
        rd(a, d);
        chk(tag, d, e);
    endtask

    // Serial monitor: decodes frames at the bench's expected bit period and
    // compares against the scoreboard queue.
    always begin : monitor
        logic [7:0] b;
        logic       stp;
        int         st;
        @(negedge clk);
        if (mon_en && tx === 1'b0) begin
            st = cyc;
            repeat (per / 2) @(negedge clk);
            chk("start_bit", 32'(tx), 32'd0);
            for (int k = 0; k < 8; k++) begin
                repeat (per) @(negedge clk);
                b[k] = tx;
            end
            repeat (per) @(negedge clk);
            stp = tx;
            chk("stop_bit", 32'(stp), 32'd1);
            if (exp_q.size() == 0) chk("rx_unexpected", {24'd0, b}, 32'hFFFF_FFFF);
            else chk("rx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
            st_q.push_back(st);
            rx_cnt++;
        end
    end

    initial begin
        rst = 1'b0; address = '0; write_data = '0; write_mask = '0; write_enable = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset mid-frame at default DIV
        wr(A_TX, 32'h00, 4'b0001);
        @(negedge clk);
        chk("tx_start_default", 32'(tx), 32'd0);
        repeat (5) @(negedge clk);
        chk("tx_still_start", 32'(tx), 32'd0);
        #2 rst = 1'b0;
        #1 chk("tx_abort_on_reset", 32'(tx), 32'd1);
        chk_rd("status_reset", A_ST, 32'h0000_0004);
        chk_rd("div_reset", A_DIV, 32'd867);
        chk("hit_base", 32'(hit), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_rd("status_after_reset", A_ST, 32'h0000_0004);

        // Single frame, DIV=3
        wr(A_DIV, 32'd3, 4'b0011);
        per = 4;
        mon_en = 1'b1;
        exp_q.push_back(8'h55);
        wr(A_TX, 32'h55, 4'b0001);
        chk("tx_idle_at_write_edge", 32'(tx), 32'd1);
        @(negedge clk);
        chk("tx_fall_latency", 32'(tx), 32'd0);
        repeat (3) @(negedge clk);
        chk("start_len_end", 32'(tx), 32'd0);
        @(negedge clk);
        chk("bit0_first", 32'(tx), 32'd1);
        repeat (35) @(negedge clk);
        chk("stop_last_cycle", 32'(tx), 32'd1);
        chk_rd("status_busy_stop", A_ST, 32'h0000_0005);
        @(negedge clk);
        chk_rd("status_idle_after_40", A_ST, 32'h0000_0004);
        chk("rx_count_single", rx_cnt, 32'd1);
        st_q.delete();

        // Fill and overflow, DIV=9
        wr(A_DIV, 32'd9, 4'b0011);
        per = 10;
        for (int i = 0; i < 6; i++) begin
            logic [7:0] v;
            v = 8'hA1 + 8'(i);
            if (i < 5) exp_q.push_back(v);
            wr(A_TX, {24'd0, v}, 4'b0001);
        end
        chk_rd("status_full_ovf", A_ST, 32'h0000_040B);
        wr(A_ST, 32'h8, 4'b0001);
        chk_rd("status_ovf_cleared", A_ST, 32'h0000_0403);
        for (int i = 0; i < 700 && rx_cnt < 6; i++) @(negedge clk);
        chk("rx_count_burst", rx_cnt, 32'd6);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        for (int i = 1; i < 5 && i < st_q.size(); i++)
            chk("frame_spacing", 32'(st_q[i] - st_q[i-1]), 32'd100);
        repeat (10) @(negedge clk);
        chk_rd("status_idle_after_burst", A_ST, 32'h0000_0004);

        // Lane masks and decode
        mon_en = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        wr(A_DIV, 32'hABCD_1234, 4'b0001);
        chk_rd("div_lane0", A_DIV, 32'h0000_0334);
        wr(A_DIV, 32'h0000_5600, 4'b0010);
        chk_rd("div_lane1", A_DIV, 32'h0000_5634);
        wr(A_DIV, 32'hFFFF_FFFF, 4'b1100);
        chk_rd("div_upper_ignored", A_DIV, 32'h0000_5634);
        wr(A_TX, 32'h77, 4'b0000);
        @(negedge clk);
        chk_rd("no_push_mask0", A_ST, 32'h0000_0004);
        chk("tx_idle_mask0", 32'(tx), 32'd1);
        chk_rd("txdata_reads_zero", A_TX, 32'd0);
        chk_rd("miss_above_rdata", A_TX + 32'd16, 32'd0);
        chk("miss_above_hit", 32'(hit), 32'd0);
        chk_rd("miss_below_rdata", A_TX - 32'd4, 32'd0);
        chk("miss_below_hit", 32'(hit), 32'd0);
`ifndef UART_TX_IRQ_EN
        wr(A_RSV, 32'hFFFF_FFFF, 4'b1111);
        chk_rd("reserved_zero", A_RSV, 32'd0);
`endif

        // DIV change mid-frame
        wr(A_DIV, 32'd1, 4'b0011);
        wr(A_TX, 32'hFF, 4'b0001);
        chk("mid_tx_idle", 32'(tx), 32'd1);
        @(negedge clk);
        chk("mid_start0", 32'(tx), 32'd0);
        @(negedge clk);
        chk("mid_start1", 32'(tx), 32'd0);
        @(negedge clk);
        chk("mid_bit0", 32'(tx), 32'd1);
        repeat (4) @(negedge clk);
        wr(A_DIV, 32'd5, 4'b0011);
        chk_rd("mid_div_read", A_DIV, 32'd5);
        repeat (36) @(negedge clk);
        chk_rd("mid_busy_last_stop", A_ST, 32'h0000_0005);
        @(negedge clk);
        chk_rd("mid_idle_after", A_ST, 32'h0000_0004);

`ifdef UART_TX_IRQ_EN
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("irq_reset", 32'(irq), 32'd0);
        wr(A_DIV, 32'd0, 4'b0011);
        wr(A_TX, 32'h3C, 4'b0001);
        wr(A_RSV, 32'd1, 4'b0001);
        for (int i = 0; i < 11; i++) begin
            chk("irq_busy", 32'(irq), 32'd0);
            @(negedge clk);
        end
        chk("irq_idle", 32'(irq), 32'd1);
        chk_rd("ie_read", A_RSV, 32'd1);
        wr(A_RSV, 32'd0, 4'b0001);
        chk("irq_hold", 32'(irq), 32'd1);
        @(negedge clk);
        chk("irq_cleared", 32'(irq), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
